// File: rtl/axi_burst_slave_if.sv
// AXI-style burst bus between one master and the burst-memory slave.
interface axi_burst_slave_if #(
  parameter int DW   = 8,
  parameter int AW   = 8,
  parameter int LENW = 4,
  parameter int IDW  = 4
);
  logic            AWVALID, AWREADY;
  logic [AW-1:0]   AWADDR;
  logic [LENW-1:0] AWLEN;
  logic [IDW-1:0]  AWID;
  logic            WVALID, WREADY, WLAST;
  logic [DW-1:0]   WDATA;
  logic            BVALID, BREADY;
  logic [IDW-1:0]  BID;
  logic [1:0]      BRESP;
  logic            ARVALID, ARREADY;
  logic [AW-1:0]   ARADDR;
  logic [LENW-1:0] ARLEN;
  logic [IDW-1:0]  ARID;
  logic            RVALID, RREADY, RLAST;
  logic [DW-1:0]   RDATA;
  logic [IDW-1:0]  RID;
  logic [1:0]      RRESP;

  modport slave (
    input  AWVALID, AWADDR, AWLEN, AWID, WVALID, WDATA, WLAST, BREADY,
           ARVALID, ARADDR, ARLEN, ARID, RREADY,
    output AWREADY, WREADY, BVALID, BID, BRESP,
           ARREADY, RVALID, RDATA, RID, RRESP, RLAST
  );

  modport master (
    output AWVALID, AWADDR, AWLEN, AWID, WVALID, WDATA, WLAST, BREADY,
           ARVALID, ARADDR, ARLEN, ARID, RREADY,
    input  AWREADY, WREADY, BVALID, BID, BRESP,
           ARREADY, RVALID, RDATA, RID, RRESP, RLAST
  );
endinterface

// File: rtl/axi_burst_slave.sv
// Burst memory slave: independent write (AW/W/B) and read (AR/R) FSMs
// sharing a 2**AW x DW memory. Addresses wrap at the top of memory.
module axi_burst_slave #(
  parameter int DW   = 8,
  parameter int AW   = 8,
  parameter int LENW = 4,
  parameter int IDW  = 4
) (
  input logic               clk,
  input logic               rst,
  axi_burst_slave_if.slave  bus
);
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA} r_state_t;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  w_state_t        w_state;
  logic [AW-1:0]   w_addr;
  logic [LENW-1:0] w_len, w_beat;
  logic [IDW-1:0]  w_id;
  logic            w_fire;

  r_state_t        r_state;
  logic [AW-1:0]   r_addr, r_addr_nxt;
  logic [LENW-1:0] r_len, r_beat;
  logic            r_fire;

  assign w_fire     = bus.WVALID & bus.WREADY;
  assign r_fire     = bus.RVALID & bus.RREADY;
  assign r_addr_nxt = r_addr + AW'(1);
  assign bus.RRESP  = 2'b00;

  // Memory has no reset so beats already written survive a reset.
  always_ff @(posedge clk) begin
    if (w_fire) mem[w_addr] <= bus.WDATA;
  end

  // Write FSM: address latch, data beats, then held response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_state     <= W_IDLE;
      bus.AWREADY <= 1'b0;
      bus.WREADY  <= 1'b0;
      bus.BVALID  <= 1'b0;
      bus.BID     <= '0;
      bus.BRESP   <= 2'b00;
      w_addr      <= '0;
      w_len       <= '0;
      w_beat      <= '0;
      w_id        <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (bus.AWVALID && bus.AWREADY) begin
            w_addr      <= bus.AWADDR;
            w_len       <= bus.AWLEN;
            w_id        <= bus.AWID;
            w_beat      <= '0;
            bus.AWREADY <= 1'b0;
            bus.WREADY  <= 1'b1;
            w_state     <= W_DATA;
          end else begin
            // Ready rises one cycle after reset release.
            bus.AWREADY <= 1'b1;
          end
        end
        W_DATA: begin
          if (w_fire) begin
            w_addr <= w_addr + AW'(1);
            w_beat <= w_beat + LENW'(1);
            // Burst ends on the programmed length or an early WLAST;
            // only WLAST landing exactly on the final beat is OKAY.
            if (w_beat == w_len || bus.WLAST) begin
              bus.WREADY <= 1'b0;
              bus.BVALID <= 1'b1;
              bus.BID    <= w_id;
              bus.BRESP  <= (w_beat == w_len && bus.WLAST) ? 2'b00 : 2'b10;
              w_state    <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (bus.BREADY) begin
            bus.BVALID  <= 1'b0;
            bus.AWREADY <= 1'b1;
            w_state     <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Read FSM: RDATA is a register loaded only on AR or R handshakes, so a
  // concurrent write to the held address cannot disturb the presented beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= R_IDLE;
      bus.ARREADY <= 1'b0;
      bus.RVALID  <= 1'b0;
      bus.RDATA   <= '0;
      bus.RID     <= '0;
      bus.RLAST   <= 1'b0;
      r_addr      <= '0;
      r_len       <= '0;
      r_beat      <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (bus.ARVALID && bus.ARREADY) begin
            r_addr      <= bus.ARADDR;
            r_len       <= bus.ARLEN;
            r_beat      <= '0;
            bus.RID     <= bus.ARID;
            bus.RDATA   <= mem[bus.ARADDR];
            bus.RLAST   <= (bus.ARLEN == '0);
            bus.ARREADY <= 1'b0;
            bus.RVALID  <= 1'b1;
            r_state     <= R_DATA;
          end else begin
            bus.ARREADY <= 1'b1;
          end
        end
        R_DATA: begin
          if (r_fire) begin
            if (bus.RLAST) begin
              bus.RVALID  <= 1'b0;
              bus.RLAST   <= 1'b0;
              bus.ARREADY <= 1'b1;
              r_state     <= R_IDLE;
            end else begin
              r_addr    <= r_addr_nxt;
              r_beat    <= r_beat + LENW'(1);
              bus.RDATA <= mem[r_addr_nxt];
              bus.RLAST <= ((r_beat + LENW'(1)) == r_len);
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_burst_slave.sv
// Directed bench for axi_burst_slave: bursts, backpressure, wrap, WLAST
// errors, read/write overlap and mid-burst reset.
module tb_axi_burst_slave;
  localparam int DW = 8, AW = 8, LENW = 4, IDW = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  axi_burst_slave_if #(.DW(DW), .AW(AW), .LENW(LENW), .IDW(IDW)) bus();
  axi_burst_slave #(.DW(DW), .AW(AW), .LENW(LENW), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] exp_mem [256];
  logic [7:0] wd [16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Write burst; last_at = beat index carrying WLAST (-1: never).
  task automatic wr(input logic [7:0] addr, input logic [3:0] len, input logic [3:0] id,
                    input int last_at, input logic [1:0] exp_resp, input int bhold);
    int n;
    logic [7:0] a;
    chk("wr_awready_idle", 32'(bus.AWREADY), 1);
    bus.AWVALID = 1; bus.AWADDR = addr; bus.AWLEN = len; bus.AWID = id;
    @(negedge clk);
    bus.AWVALID = 0;
    chk("wr_wready", 32'(bus.WREADY), 1);
    chk("wr_awready_busy", 32'(bus.AWREADY), 0);
    n = (last_at >= 0 && last_at < int'(len)) ? last_at + 1 : int'(len) + 1;
    for (int i = 0; i < n; i++) begin
      bus.WVALID = 1; bus.WDATA = wd[i]; bus.WLAST = (i == last_at);
      @(negedge clk);
      a = addr + 8'(i);
      exp_mem[a] = wd[i];
      if (i < n - 1) chk("wr_bvalid_early", 32'(bus.BVALID), 0);
    end
    bus.WVALID = 0; bus.WLAST = 0;
    chk("wr_bvalid", 32'(bus.BVALID), 1);
    chk("wr_bid", 32'(bus.BID), 32'(id));
    chk("wr_bresp", 32'(bus.BRESP), 32'(exp_resp));
    chk("wr_wready_done", 32'(bus.WREADY), 0);
    for (int h = 0; h < bhold; h++) begin
      @(negedge clk);
      chk("wr_bhold_bvalid", 32'(bus.BVALID), 1);
      chk("wr_bhold_bresp", 32'(bus.BRESP), 32'(exp_resp));
      chk("wr_bhold_awready", 32'(bus.AWREADY), 0);
    end
    bus.BREADY = 1;
    @(negedge clk);
    bus.BREADY = 0;
    chk("wr_bvalid_clr", 32'(bus.BVALID), 0);
    chk("wr_awready_back", 32'(bus.AWREADY), 1);
  endtask

  // Read burst; RREADY dropped for hold_n cycles at beat hold_beat.
  task automatic rd(input logic [7:0] addr, input logic [3:0] len, input logic [3:0] id,
                    input int hold_beat, input int hold_n);
    logic [7:0] a;
    chk("rd_arready_idle", 32'(bus.ARREADY), 1);
    bus.ARVALID = 1; bus.ARADDR = addr; bus.ARLEN = len; bus.ARID = id;
    @(negedge clk);
    bus.ARVALID = 0; bus.RREADY = 1;
    for (int i = 0; i <= int'(len); i++) begin
      a = addr + 8'(i);
      chk("rd_rvalid", 32'(bus.RVALID), 1);
      chk("rd_rdata", 32'(bus.RDATA), 32'(exp_mem[a]));
      chk("rd_rid", 32'(bus.RID), 32'(id));
      chk("rd_rlast", 32'(bus.RLAST), 32'(i == int'(len)));
      if (i == hold_beat) begin
        bus.RREADY = 0;
        for (int h = 0; h < hold_n; h++) begin
          @(negedge clk);
          chk("rd_hold_rdata", 32'(bus.RDATA), 32'(exp_mem[a]));
          chk("rd_hold_rlast", 32'(bus.RLAST), 32'(i == int'(len)));
          chk("rd_hold_rvalid", 32'(bus.RVALID), 1);
        end
        bus.RREADY = 1;
      end
      @(negedge clk);
    end
    bus.RREADY = 0;
    chk("rd_rvalid_clr", 32'(bus.RVALID), 0);
    chk("rd_arready_back", 32'(bus.ARREADY), 1);
  endtask

  initial begin
    bus.AWVALID = 0; bus.AWADDR = 0; bus.AWLEN = 0; bus.AWID = 0;
    bus.WVALID = 0; bus.WDATA = 0; bus.WLAST = 0; bus.BREADY = 0;
    bus.ARVALID = 0; bus.ARADDR = 0; bus.ARLEN = 0; bus.ARID = 0; bus.RREADY = 0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_awready", 32'(bus.AWREADY), 0);
    chk("rst_arready", 32'(bus.ARREADY), 0);
    chk("rst_wready", 32'(bus.WREADY), 0);
    chk("rst_bvalid", 32'(bus.BVALID), 0);
    chk("rst_rvalid", 32'(bus.RVALID), 0);
    chk("rst_rdata", 32'(bus.RDATA), 0);
    chk("rst_bresp", 32'(bus.BRESP), 0);
    rst = 1;
    @(negedge clk);
    chk("post_rst_awready", 32'(bus.AWREADY), 1);
    chk("post_rst_arready", 32'(bus.ARREADY), 1);

    // Basic 3-beat write and read back
    wd[0] = 8'h01; wd[1] = 8'h02; wd[2] = 8'h03;
    wr(8'h01, 4'd2, 4'd1, 2, 2'b00, 0);
    rd(8'h01, 4'd2, 4'd1, -1, 0);

    // Backpressure: BREADY low 4 cycles, RREADY low 3 cycles mid-burst
    wd[0] = 8'h31; wd[1] = 8'h32;
    wr(8'h30, 4'd1, 4'd5, 1, 2'b00, 4);
    rd(8'h01, 4'd2, 4'd1, 1, 3);

    // Address wrap
    wd[0] = 8'hAA; wd[1] = 8'hBB;
    wr(8'hFF, 4'd1, 4'd2, 1, 2'b00, 0);
    chk("wrap_mem_ff", 32'(exp_mem[8'hFF]), 32'h0AA);
    chk("wrap_mem_00", 32'(exp_mem[8'h00]), 32'h0BB);
    rd(8'hFF, 4'd1, 4'd2, -1, 0);

    // Early WLAST with a concurrent read burst
    wd[0] = 8'h11; wd[1] = 8'h22;
    fork
      wr(8'h01, 4'd3, 4'd6, 1, 2'b10, 0);
      rd(8'hFF, 4'd1, 4'd7, -1, 0);
    join
    rd(8'h01, 4'd2, 4'd1, -1, 0);   // expects 11,22,03

    // Missing WLAST
    wd[0] = 8'h41; wd[1] = 8'h42;
    wr(8'h40, 4'd1, 4'd3, -1, 2'b10, 0);
    rd(8'h40, 4'd1, 4'd3, -1, 0);

    // Write to the address whose data is held in RDATA
    bus.ARVALID = 1; bus.ARADDR = 8'h40; bus.ARLEN = 0; bus.ARID = 4'd4;
    @(negedge clk);
    bus.ARVALID = 0;
    chk("hold_rdata_pre", 32'(bus.RDATA), 32'h41);
    wd[0] = 8'h99;
    wr(8'h40, 4'd0, 4'd4, 0, 2'b00, 0);
    chk("hold_rvalid", 32'(bus.RVALID), 1);
    chk("hold_rdata_post", 32'(bus.RDATA), 32'h41);
    chk("hold_rlast", 32'(bus.RLAST), 1);
    bus.RREADY = 1;
    @(negedge clk);
    bus.RREADY = 0;
    chk("hold_rvalid_clr", 32'(bus.RVALID), 0);
    rd(8'h40, 4'd0, 4'd4, -1, 0);

    // Reset mid-burst on both channels
    bus.AWVALID = 1; bus.AWADDR = 8'h50; bus.AWLEN = 4'd3; bus.AWID = 4'd2;
    bus.ARVALID = 1; bus.ARADDR = 8'h01; bus.ARLEN = 4'd2; bus.ARID = 4'd3;
    @(negedge clk);
    bus.AWVALID = 0; bus.ARVALID = 0;
    bus.WVALID = 1; bus.WDATA = 8'h5A; bus.RREADY = 1;
    chk("mr_rdata0", 32'(bus.RDATA), 32'h11);
    @(negedge clk);
    bus.WDATA = 8'h5B; bus.RREADY = 0;
    chk("mr_rdata1", 32'(bus.RDATA), 32'h22);
    @(negedge clk);
    bus.WVALID = 0;
    exp_mem[8'h50] = 8'h5A; exp_mem[8'h51] = 8'h5B;
    chk("mr_rvalid_pre", 32'(bus.RVALID), 1);
    chk("mr_wready_pre", 32'(bus.WREADY), 1);
    #2 rst = 0;
    #1;
    chk("mr_rvalid_async", 32'(bus.RVALID), 0);
    chk("mr_wready_async", 32'(bus.WREADY), 0);
    chk("mr_bvalid_async", 32'(bus.BVALID), 0);
    chk("mr_rdata_async", 32'(bus.RDATA), 0);
    chk("mr_arready_async", 32'(bus.ARREADY), 0);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("mr_arready_release", 32'(bus.ARREADY), 1);
    chk("mr_awready_release", 32'(bus.AWREADY), 1);
    rd(8'h50, 4'd1, 4'd8, -1, 0);
    rd(8'h01, 4'd2, 4'd9, -1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
